// File: rtl/pipe_if_stage.sv
// Instruction-fetch stage and IF/ID register of the 5-stage MIPS pipeline, delayed-branch aware.
// Optional macro IF_SQUASH_EN: annul the delay-slot word whenever a redirect is taken.
module pipe_if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        clrn,
  input  logic [1:0]  pcsource,
  input  logic [31:0] bpc,
  input  logic [31:0] rpc,
  input  logic [31:0] jpc,
  input  logic        nostall,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ready,
  output logic [31:0] pc,
  output logic [31:0] dpc4,
  output logic [31:0] inst,
  output logic        dvalid
);

  localparam int unsigned XW = 32;

  logic          redir_valid, redir_valid_n;
  logic [XW-1:0] redir_pc, redir_pc_n;
  logic [XW-1:0] pc_n, dpc4_n, inst_n;
  logic          dvalid_n, imem_req_n;
  logic [XW-1:0] pc4, sel_target, npc;
  logic          advance, redirect_req;

  assign imem_addr    = pc;
  assign pc4          = pc + XW'(4);
  assign advance      = nostall & imem_req & imem_ready;
  assign redirect_req = (pcsource != 2'b00);

  // Decode-side target select; a latched redirect always takes priority.
  always_comb begin
    sel_target = pc4;
    case (pcsource)
      2'b00:   sel_target = pc4;
      2'b01:   sel_target = bpc;
      2'b10:   sel_target = rpc;
      default: sel_target = jpc;
    endcase
    npc = redir_valid ? redir_pc : sel_target;
  end

  // Next-state logic for PC, IF/ID and the pending-redirect register.
  always_comb begin
    pc_n          = pc;
    dpc4_n        = dpc4;
    inst_n        = inst;
    dvalid_n      = dvalid;
    redir_valid_n = redir_valid;
    redir_pc_n    = redir_pc;
    imem_req_n    = 1'b1;
    if (nostall) begin
      if (advance) begin
        pc_n          = npc;
        dpc4_n        = pc4;
        inst_n        = imem_rdata;
        dvalid_n      = 1'b1;
        redir_valid_n = 1'b0;
`ifdef IF_SQUASH_EN
        if (redirect_req || redir_valid) begin
          inst_n   = NOP_INST;
          dvalid_n = 1'b0;
        end
`endif
      end else begin
        inst_n   = NOP_INST;
        dvalid_n = 1'b0;
        // Remember the branch target while the delay slot is still being fetched.
        if (redirect_req && !redir_valid) begin
          redir_pc_n    = sel_target;
          redir_valid_n = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      pc          <= RESET_PC;
      dpc4        <= '0;
      inst        <= NOP_INST;
      dvalid      <= 1'b0;
      redir_valid <= 1'b0;
      redir_pc    <= '0;
      imem_req    <= 1'b0;
    end else begin
      pc          <= pc_n;
      dpc4        <= dpc4_n;
      inst        <= inst_n;
      dvalid      <= dvalid_n;
      redir_valid <= redir_valid_n;
      redir_pc    <= redir_pc_n;
      imem_req    <= imem_req_n;
    end
  end

endmodule

// File: tb/tb_pipe_if_stage.sv
// Self-checking bench for pipe_if_stage: directed delayed-branch scenarios plus randomized traffic.
module tb_pipe_if_stage;

  logic        clk = 1'b0;
  logic        clrn;
  logic [1:0]  pcsource;
  logic [31:0] bpc, rpc, jpc;
  logic        nostall;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ready;
  logic [31:0] pc, dpc4, inst;
  logic        dvalid;

  int errors = 0;
  int checks = 0;

  // Reference state: architectural view of the fetch stage.
  logic [31:0] m_pc, m_dpc4, m_inst;
  logic        m_dvalid, m_req;
  logic [31:0] pend_q[$];

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1234_5678;
  endfunction

  assign imem_rdata = mem_word(imem_addr);

  pipe_if_stage dut (
    .clk(clk), .clrn(clrn), .pcsource(pcsource), .bpc(bpc), .rpc(rpc), .jpc(jpc),
    .nostall(nostall), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .imem_ready(imem_ready), .pc(pc), .dpc4(dpc4),
    .inst(inst), .dvalid(dvalid)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc = 32'h0; m_dpc4 = 32'h0; m_inst = 32'h0; m_dvalid = 1'b0; m_req = 1'b0;
    pend_q.delete();
  endtask

  // One clock of fetch behaviour described in terms of the delayed-branch contract.
  task automatic model_edge();
    logic [31:0] target;
    logic        fetched, redirecting;
    fetched = nostall && m_req && imem_ready;
    case (pcsource)
      2'b01:   target = bpc;
      2'b10:   target = rpc;
      2'b11:   target = jpc;
      default: target = m_pc + 32'd4;
    endcase
    if (nostall) begin
      if (fetched) begin
        redirecting = (pcsource != 2'b00) || (pend_q.size() != 0);
        m_inst   = mem_word(m_pc);
        m_dvalid = 1'b1;
`ifdef IF_SQUASH_EN
        if (redirecting) begin
          m_inst = 32'h0; m_dvalid = 1'b0;
        end
`endif
        m_dpc4 = m_pc + 32'd4;
        m_pc   = (pend_q.size() != 0) ? pend_q.pop_front() : target;
      end else begin
        m_inst = 32'h0; m_dvalid = 1'b0;
        if (pcsource != 2'b00 && pend_q.size() == 0) pend_q.push_back(target);
      end
    end
    m_req = 1'b1;
  endtask

  task automatic compare_all(input string ph);
    check({ph, ".pc"}, pc, m_pc);
    check({ph, ".imem_addr"}, imem_addr, m_pc);
    check({ph, ".dpc4"}, dpc4, m_dpc4);
    check({ph, ".inst"}, inst, m_inst);
    check({ph, ".dvalid"}, 32'(dvalid), 32'(m_dvalid));
    check({ph, ".imem_req"}, 32'(imem_req), 32'(m_req));
  endtask

  task automatic step(input logic ns, input logic rdy, input logic [1:0] ps,
                      input logic [31:0] b, input logic [31:0] r, input logic [31:0] j);
    nostall = ns; imem_ready = rdy; pcsource = ps; bpc = b; rpc = r; jpc = j;
    @(posedge clk);
    model_edge();
    #1;
    compare_all("cyc");
  endtask

  task automatic do_reset();
    #2 clrn = 1'b0;
    #1 model_reset();
    compare_all("rst");
    @(negedge clk);
    clrn = 1'b1;
  endtask

  initial begin
    clrn = 1'b1; nostall = 1'b1; imem_ready = 1'b0; pcsource = 2'b00;
    bpc = '0; rpc = '0; jpc = '0;
    model_reset();
    #1 clrn = 1'b0;
    #1 compare_all("por");
    @(negedge clk);
    clrn = 1'b1;

    // Sequential fetch from reset
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 2'b00, '0, '0, '0);
    check("seq_pc", pc, 32'hC);
    check("seq_dpc4", dpc4, 32'hC);

    // Wait states at 0x40
    step(1'b1, 1'b1, 2'b11, '0, '0, 32'h40);
    step(1'b1, 1'b0, 2'b00, '0, '0, '0);
    step(1'b1, 1'b0, 2'b00, '0, '0, '0);
    check("wait_pc", pc, 32'h40);
    check("wait_dvalid", 32'(dvalid), 32'h0);
    step(1'b1, 1'b1, 2'b00, '0, '0, '0);
    check("wait_inst", inst, mem_word(32'h40));
    check("wait_dpc4", dpc4, 32'h44);

    // Branch with ready delay slot
    step(1'b1, 1'b1, 2'b11, '0, '0, 32'h20);
    step(1'b1, 1'b1, 2'b01, 32'h100, '0, '0);
    check("br_pc", pc, 32'h100);
`ifdef IF_SQUASH_EN
    check("br_inst", inst, 32'h0);
`else
    check("br_inst", inst, mem_word(32'h20));
`endif

    // Branch with delay slot waiting 3 cycles
    step(1'b1, 1'b1, 2'b11, '0, '0, 32'h20);
    step(1'b1, 1'b0, 2'b01, 32'h100, '0, '0);
    step(1'b1, 1'b0, 2'b00, '0, '0, '0);
    step(1'b1, 1'b0, 2'b00, '0, '0, '0);
    check("brw_hold_pc", pc, 32'h20);
    step(1'b1, 1'b1, 2'b00, '0, '0, '0);
    check("brw_pc", pc, 32'h100);
    check("brw_dpc4", dpc4, 32'h24);

    // Stall ignores pcsource
    step(1'b0, 1'b1, 2'b11, '0, '0, 32'h200);
    step(1'b0, 1'b1, 2'b11, '0, '0, 32'h200);
    check("stall_pc", pc, 32'h100);
    check("stall_dpc4", dpc4, 32'h24);

    // PC wrap
    step(1'b1, 1'b1, 2'b11, '0, '0, 32'hFFFF_FFFC);
    step(1'b1, 1'b1, 2'b00, '0, '0, '0);
    check("wrap_pc", pc, 32'h0);
    check("wrap_dpc4", dpc4, 32'h0);

    // Reset mid-wait drops the pending redirect
    step(1'b1, 1'b1, 2'b11, '0, '0, 32'h20);
    step(1'b1, 1'b0, 2'b01, 32'h100, '0, '0);
    do_reset();
    step(1'b1, 1'b1, 2'b00, '0, '0, '0);
    step(1'b1, 1'b1, 2'b00, '0, '0, '0);
    check("rstwait_pc", pc, 32'h4);

    // Randomized traffic with occasional reset
    for (int i = 0; i < 600; i++) begin
      logic [1:0] ps;
      ps = ($urandom_range(0, 99) < 70) ? 2'b00 : 2'($urandom_range(1, 3));
      if ($urandom_range(0, 99) == 0) do_reset();
      step($urandom_range(0, 99) < 85, $urandom_range(0, 99) < 70, ps,
           $urandom, $urandom, $urandom);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pipe_if_stage.md
Name: pipe_if_stage

Overview:
- Instruction-fetch stage plus IF/ID pipeline register of the 5-stage MIPS pipeline.
- Holds the PC and selects the next PC from the decode stage's pcsource, bpc, register target and jpc.
- Drives a single-cycle-handshake instruction memory and presents dpc4/inst to the decode stage.
- Keeps one-instruction delayed-branch semantics across instruction-memory wait states, using a pending-redirect register.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INST, 32'h0000_0000, bubble instruction (sll $0,$0,0) inserted into IF/ID.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- clrn  input  1  asynchronous active-low reset.
- pcsource  input  2  next-PC select from decode: 00 pc+4, 01 bpc, 10 rpc, 11 jpc.
- bpc  input  32  branch target from decode.
- rpc  input  32  jr target (forwarded rs value) from decode.
- jpc  input  32  jump target from decode.
- nostall  input  1  decode-stage enable; 0 freezes PC and IF/ID.
- imem_req  output  1  fetch request.
- imem_addr  output  32  fetch address; equals pc.
- imem_rdata  input  32  fetched word; valid when imem_ready=1.
- imem_ready  input  1  same-cycle fetch completion.
- pc  output  32  current fetch PC.
- dpc4  output  32  IF/ID: PC+4 of the held instruction.
- inst  output  32  IF/ID: held instruction.
- dvalid  output  1  IF/ID holds a real (non-bubble) instruction.

Behaviour:
- Reset (clrn=0, asynchronous, overrides everything):
  - pc=RESET_PC, dpc4=0, inst=NOP_INST, dvalid=0.
  - redir_valid=0, redir_pc=0, imem_req=0.
- imem_req goes to 1 on the first rising edge after reset release and stays 1.
- imem_addr=pc, combinational. pc4=pc+32'd4, modulo 2^32 (0xFFFF_FFFC wraps to 0).
- npc: if redir_valid then redir_pc; else mux(pcsource: pc4, bpc, rpc, jpc).
- advance = nostall & imem_req & imem_ready.
- Each rising edge, exactly one case applies:
  - nostall=0: pc, IF/ID, redir state all hold. pcsource is ignored (decode may be mid load-use stall).
  - advance=1:
    - pc<=npc; dpc4<=pc4; inst<=imem_rdata; dvalid<=1; redir_valid<=0.
    - Latency: a fetch issued in cycle N appears on inst/dvalid in cycle N+1.
  - nostall=1, not ready:
    - pc holds; inst<=NOP_INST; dvalid<=0; dpc4 holds.
    - If pcsource!=00 and redir_valid=0: redir_pc<=selected target, redir_valid<=1.
    - Otherwise redir state holds.
- Delayed branch: the instruction fetched while a branch/jump is in decode (the delay slot) always executes. The redirect takes effect on the fetch after it, including when the delay-slot fetch waited.
- redir_valid=1 and pcsource!=00 together cannot arise legally, because decode holds a bubble. If it does occur, redir_pc wins.
- Reset asserted mid-wait discards pending redirect and IF/ID contents.
- Unaligned targets are passed through unchanged; no trap.

Optional Feature:
- Macro IF_SQUASH_EN.
- Defined (annulled-branch mode): on advance, when pcsource!=00 or redir_valid=1, the delay-slot word is squashed.
  - inst<=NOP_INST, dvalid<=0; pc still <=npc.
  - The redirect still happens.
- Undefined: delay slot executes as described in Behaviour; no squash logic is present.

Test Plan:
- Reset then imem_ready=1, pcsource=00, nostall=1 for 4 cycles -> pc sequence 0,4,8,C; inst follows imem_rdata one cycle later; dpc4=4,8,C.
- pc=0x40, imem_ready=0 for 2 cycles -> pc stays 0x40; inst=0; dvalid=0; then ready -> inst=word@0x40, dpc4=0x44.
- Branch in decode, pcsource=01, bpc=0x100, pc=0x20 (delay slot), ready=1 -> next pc=0x100; inst=word@0x20, dvalid=1.
- Same branch but ready=0 for 3 cycles on the delay slot -> redir_valid=1, pc=0x20 held; on ready, inst=word@0x20 and pc=0x100.
- nostall=0 for 2 cycles with pcsource=11, jpc=0x200 -> pc, inst, dpc4 unchanged; pcsource ignored.
- pc=0xFFFF_FFFC, pcsource=00, ready=1 -> pc=0, dpc4=0. With IF_SQUASH_EN defined, repeat the pcsource=01 case -> inst=0, dvalid=0, pc=0x100.
